incr_dp_scheduler: RTL and testbench

//  Shares one fixed-latency "+1" datapath (request/input_data in, final_resp out) between NUM_REQ

---
 rtl/incr_dp_scheduler.sv | 165 ++++++++++++++++
 tb/tb_incr_dp_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/incr_dp_scheduler.sv
// incr_dp_scheduler: round-robin sharing of one fixed-latency "+1" datapath between
// NUM_REQ requesters, with a tracking pipe that aligns id/valid/expected result to the
// datapath output and flags any response that differs from issued operand + 1.
module incr_dp_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_dp_request,
  output logic [DATA_W-1:0]         o_dp_input_data,
  input  logic [DATA_W-1:0]         i_dp_final_resp,
  output logic                      o_resp_valid,
  output logic [ID_W-1:0]           o_resp_id,
  output logic [DATA_W-1:0]         o_resp_data,
  output logic                      o_resp_err,
  output logic                      o_busy
);

  localparam int unsigned LAST = LATENCY - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One in-flight entry: valid flag, requester id and the result the datapath should return.
  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] expd;
  } trk_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  trk_t                r_pipe [LATENCY];

  logic [NUM_REQ-1:0]  w_hi_req;
  logic [NUM_REQ-1:0]  w_cand;
  logic                w_found;
  logic [ID_W-1:0]     w_grant;
  logic                w_xfer;
  logic                w_pipe_empty;

  // Round-robin pick: lowest valid index at/above the pointer, else lowest valid overall.
  always_comb begin
    w_hi_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_hi_req[i] = i_req_valid[i] & (32'(i) >= 32'(r_ptr));
    end
    w_cand  = (|w_hi_req) ? w_hi_req : i_req_valid;
    w_found = |w_cand;
    w_grant = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_grant = ID_W'(i);
      end
    end
  end

  assign w_xfer       = (r_state == ST_RUN) && w_found;
  assign o_dp_request = w_xfer;

  // Grant and operand mux, both zero unless a transfer happens this cycle.
  always_comb begin
    o_req_ready     = '0;
    o_dp_input_data = '0;
    if (w_xfer) begin
      o_req_ready[w_grant] = 1'b1;
      o_dp_input_data      = i_req_data[32'(w_grant)*DATA_W +: DATA_W];
    end
  end

  // Pointer moves just past the granted requester; holds when nothing transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      if (32'(w_grant) == NUM_REQ - 1) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_grant + ID_W'(1);
      end
    end
  end

  // Tracking pipe: stage 0 captures the issue, then shifts one stage per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_xfer;
      r_pipe[0].id    <= w_xfer ? w_grant : '0;
      r_pipe[0].expd  <= o_dp_input_data + DATA_W'(1);
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Response register: captures the datapath result on the same edge the final stage retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_resp_valid <= 1'b0;
      o_resp_id    <= '0;
      o_resp_data  <= '0;
      o_resp_err   <= 1'b0;
    end else begin
      o_resp_valid <= r_pipe[LAST].valid;
      o_resp_id    <= r_pipe[LAST].id;
      o_resp_data  <= i_dp_final_resp;
      o_resp_err   <= r_pipe[LAST].valid && (i_dp_final_resp != r_pipe[LAST].expd);
    end
  end

  // Nothing outstanding: no live stage and no response being presented.
  always_comb begin
    w_pipe_empty = !o_resp_valid;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      if (r_pipe[i].valid) begin
        w_pipe_empty = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enable is sampled for the next state only, so a request in the cycle
  // enable falls is still granted; a re-enable during drain resumes issuing at once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_enable) w_state_nxt = ST_RUN;
      ST_RUN:   if (!i_enable) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (i_enable) begin
          w_state_nxt = ST_RUN;
        end else if (w_pipe_empty) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_incr_dp_scheduler.sv
// Bench for incr_dp_scheduler: directed scenarios plus a randomized phase, all checked
// cycle by cycle against a behavioural model (issue history + round-robin arithmetic).
module tb_incr_dp_scheduler;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned ID_W    = 1;
  localparam int          HIST    = 4096;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      dp_request;
  logic [DATA_W-1:0]         dp_input_data;
  logic [DATA_W-1:0]         dp_final_resp;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;
  logic                      busy;

  incr_dp_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (enable),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .o_req_ready     (req_ready),
    .o_dp_request    (dp_request),
    .o_dp_input_data (dp_input_data),
    .i_dp_final_resp (dp_final_resp),
    .o_resp_valid    (resp_valid),
    .o_resp_id       (resp_id),
    .o_resp_data     (resp_data),
    .o_resp_err      (resp_err),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  // Datapath model: +1 with LATENCY register stages; skew mode adds one more stage on data.
  logic [DATA_W-1:0] dp_pipe [LATENCY];
  logic [DATA_W-1:0] dp_late;
  bit                skew;

  initial begin
    for (int i = 0; i < int'(LATENCY); i++) dp_pipe[i] = '0;
    dp_late = '0;
    skew    = 1'b0;
  end

  always @(posedge clk) begin
    dp_pipe[0] <= dp_input_data + DATA_W'(1);
    for (int i = 1; i < int'(LATENCY); i++) dp_pipe[i] <= dp_pipe[i-1];
    dp_late <= dp_pipe[LATENCY-1];
  end

  assign dp_final_resp = skew ? dp_late : dp_pipe[LATENCY-1];

  // Scoreboard counters and reference-model state.
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  bit                m_run    = 1'b0;
  bit                m_busy   = 1'b0;
  int                m_ptr    = 0;
  int                last_issue = -100;
  int                last_rst   = -1;
  bit                iss    [HIST];
  int                iss_id [HIST];
  logic [DATA_W-1:0] hist   [HIST];
  int                skew_resps = 0;
  int                skew_errs  = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, step the model across the edge,
  // then check registered outputs against the model.
  task automatic run_cycle(input logic en, input logic rstn, input logic [NUM_REQ-1:0] v,
                           input logic [NUM_REQ*DATA_W-1:0] d);
    bit                found;
    int                g;
    int                idx;
    bit                do_issue;
    bit                empty;
    bit                exp_v;
    int                n;
    logic [DATA_W-1:0] exp_in;
    logic [DATA_W-1:0] good;
    logic [DATA_W-1:0] dp_out;
    enable    = en;
    rst_n     = rstn;
    req_valid = v;
    req_data  = d;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (m_ptr + k) % int'(NUM_REQ);
      if (!found && v[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    do_issue = m_run && found;
    exp_in   = do_issue ? d[g*DATA_W +: DATA_W] : '0;
    @(negedge clk);
    chk_eq("req_ready", 64'(req_ready), do_issue ? (64'(1) << g) : 64'(0));
    chk_eq("dp_request", 64'(dp_request), 64'(do_issue));
    chk_eq("dp_input_data", 64'(dp_input_data), 64'(exp_in));
    hist[cyc]   = exp_in;
    iss[cyc]    = do_issue;
    iss_id[cyc] = g;
    empty = (cyc - last_issue) > int'(LATENCY) + 1;
    @(posedge clk);
    #1;
    if (!rstn) begin
      m_run      = 1'b0;
      m_busy     = 1'b0;
      m_ptr      = 0;
      last_issue = -100;
      last_rst   = cyc;
    end else begin
      m_busy = en ? 1'b1 : (m_run ? 1'b1 : (m_busy && !empty));
      m_run  = en;
      if (do_issue) begin
        m_ptr      = (g + 1) % int'(NUM_REQ);
        last_issue = cyc;
      end
    end
    cyc++;
    n     = cyc - int'(LATENCY) - 1;
    exp_v = (n >= 1) && (n > last_rst) && iss[n];
    chk_eq("busy", 64'(busy), 64'(m_busy));
    chk_eq("resp_valid", 64'(resp_valid), 64'(exp_v));
    if (exp_v) begin
      good   = hist[n] + DATA_W'(1);
      dp_out = skew ? hist[n-1] + DATA_W'(1) : good;
      chk_eq("resp_id", 64'(resp_id), 64'(iss_id[n]));
      chk_eq("resp_data", 64'(resp_data), 64'(dp_out));
      chk_eq("resp_err", 64'(resp_err), 64'(dp_out != good));
      if (skew) begin
        skew_resps++;
        if (resp_err) skew_errs++;
      end
    end else begin
      chk_eq("resp_err_idle", 64'(resp_err), 64'(0));
    end
  endtask

  task automatic idle_cycles(input logic en, input int cnt);
    for (int i = 0; i < cnt; i++) run_cycle(en, 1'b1, '0, '0);
  endtask

  logic [NUM_REQ*DATA_W-1:0] dat;
  logic                      ren;

  initial begin
    rst_n = 1'b0; enable = 1'b0; req_valid = '0; req_data = '0;
    @(posedge clk);
    #1;
    // Reset
    run_cycle(1'b0, 1'b0, '0, '0);
    run_cycle(1'b0, 1'b0, '0, '0);
    idle_cycles(1'b0, 2);
    // Single request on requester 0
    idle_cycles(1'b1, 1);
    run_cycle(1'b1, 1'b1, 2'b01, {32'h0, 32'h10});
    idle_cycles(1'b1, 4);
    // Contention: both valid for 6 cycles
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 2'b11, {32'hA000 + 32'(i), 32'hB000 + 32'(i)});
    idle_cycles(1'b1, 4);
    // Wrap on requester 1
    run_cycle(1'b1, 1'b1, 2'b10, {32'hFFFF_FFFF, 32'h0});
    idle_cycles(1'b1, 4);
    // Skewed datapath: isolated nonzero requests, every response must flag
    skew = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dat = {32'($urandom_range(1, 32'h7FFF_FFFF)), 32'($urandom_range(1, 32'h7FFF_FFFF))};
      run_cycle(1'b1, 1'b1, 2'($urandom_range(1, 3)), dat);
      idle_cycles(1'b1, 3);
    end
    chk_eq("skew_err_count", 64'(skew_errs), 64'(skew_resps));
    chk_eq("skew_resp_count", 64'(skew_resps), 64'(6));
    skew = 1'b0;
    idle_cycles(1'b1, 4);
    // Drain: two back-to-back issues, enable falls with the second, requests keep pending
    run_cycle(1'b1, 1'b1, 2'b11, {32'h22, 32'h11});
    run_cycle(1'b0, 1'b1, 2'b11, {32'h44, 32'h33});
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 2'b11, {32'h66, 32'h55});
    idle_cycles(1'b0, 2);
    // Reset with two in flight, then first grant must go to requester 0
    idle_cycles(1'b1, 1);
    run_cycle(1'b1, 1'b1, 2'b01, {32'h0, 32'h70});
    run_cycle(1'b1, 1'b1, 2'b10, {32'h71, 32'h0});
    run_cycle(1'b1, 1'b0, 2'b00, '0);
    idle_cycles(1'b1, 1);
    run_cycle(1'b1, 1'b1, 2'b11, {32'h81, 32'h80});
    idle_cycles(1'b1, 4);
    // Randomized traffic with sticky enable and rare resets
    ren = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ren = ~ren;
      dat = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) dat[DATA_W-1:0] = '1;
      run_cycle(ren, ($urandom_range(0, 99) != 0), 2'($urandom), dat);
    end
    idle_cycles(1'b0, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
